systolic_seq_ctrl: RTL and testbench

Parametrised sequencer for an output-stationary ROWS x COLS systolic multiply array computing C = A(ROWS x k_len) * B(k_len x COLS). On a start request it:
- clears the PE accumulators;
- issues diagonally skewed per-row and per-column operand-feed enables for a runtime-selectable depth k_len;
- keeps the array advancing until the last PE has consumed its last operand;
- pulses done.

It sits between the matrix-operand buffers and the PE grid, and supports stall and abort.

---
 rtl/systolic_seq_ctrl.sv | 59 +++++
 tb/tb_systolic_seq_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: clear/feed/done sequencer with skewed row/column operand enables for a systolic array
module systolic_seq_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            stall,
  input  logic            abort,
  output logic            busy,
  output logic            acc_clr,
  output logic            pe_en,
  output logic [ROWS-1:0] a_en,
  output logic [COLS-1:0] b_en,
  output logic            done
);
  localparam int TW = $clog2((1 << KW) + ROWS + COLS);
  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;
  state_t state, nxt;
  logic [KW-1:0] k_reg;
  logic [TW-1:0] t, total;
  logic run;
  assign total = TW'(k_reg) + TW'(ROWS + COLS - 2);
  assign run = state == FEED && !stall && !abort;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      t <= '0;
      k_reg <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) k_reg <= k_len;
      t <= state == CLEAR ? '0 : run ? t + TW'(1) : t;
    end
  always_comb begin
    nxt = state;
    if (state == IDLE) nxt = !start ? IDLE : k_len == '0 ? DONE : CLEAR;
    else if (abort) nxt = IDLE;
    else if (state == CLEAR) nxt = FEED;
    else if (state == FEED) nxt = (!stall && t == total - TW'(1)) ? DONE : FEED;
    else nxt = IDLE;
  end
  // t is the skew reference: row r / column c is live for k_reg cycles starting at t == r / c
  always_comb begin
    busy = state != IDLE;
    acc_clr = state == CLEAR && !abort;
    pe_en = run;
    done = state == DONE && !abort;
    a_en = '0;
    b_en = '0;
    for (int r = 0; r < ROWS; r++)
      a_en[r] = run && t >= TW'(r) && t < TW'(r) + TW'(k_reg);
    for (int c = 0; c < COLS; c++)
      b_en[c] = run && t >= TW'(c) && t < TW'(c) + TW'(k_reg);
  end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: directed bench with cycle-level behavioural model for 4x4 and 2x8 sequencers
module tb_systolic_seq_ctrl;
  logic clk = 0, rst = 0, start = 0, stall = 0, abort = 0;
  logic [7:0] k_len = 0;
  logic busy1, acc1, pe1, done1;
  logic [3:0] a1, b1;
  logic busy2, acc2, pe2, done2;
  logic [1:0] a2;
  logic [7:0] b2;
  int cyc = 0, c0 = 0, rel, n_chk = 0, n_fail = 0;
  logic [63:0] h_pe, h_a0, h_a3, h_b2, h_done, h_acc, h_busy;
  int b7_first, b7_last, b7_cnt, d2;
  typedef struct packed {logic busy, acc, pe, done; logic [7:0] a, b;} out_t;
  typedef struct packed {bit act; int k; int p;} m_t;
  m_t m1, m2;
  out_t e1, e2, g1, g2;

  systolic_seq_ctrl #(.ROWS(4), .COLS(4), .KW(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .stall(stall), .abort(abort),
    .busy(busy1), .acc_clr(acc1), .pe_en(pe1), .a_en(a1), .b_en(b1), .done(done1));
  systolic_seq_ctrl #(.ROWS(2), .COLS(8), .KW(8)) dut2 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .stall(stall), .abort(abort),
    .busy(busy2), .acc_clr(acc2), .pe_en(pe2), .a_en(a2), .b_en(b2), .done(done2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: p counts cycles since acceptance (p=0 clear, 1..total feed with t=p-1, total+1 done), stalls freeze p
  function automatic out_t model_out(int R, int C, m_t m, bit st, bit ab);
    out_t o;
    int total, t;
    o = '0;
    total = m.k + R + C - 2;
    if (!m.act) return o;
    o.busy = 1;
    if (m.k == 0) o.done = !ab;
    else if (m.p == 0) o.acc = !ab;
    else if (m.p <= total) begin
      if (!st && !ab) begin
        t = m.p - 1;
        o.pe = 1;
        for (int r = 0; r < R; r++) o.a[r] = t >= r && t < r + m.k;
        for (int c = 0; c < C; c++) o.b[c] = t >= c && t < c + m.k;
      end
    end else o.done = !ab;
    return o;
  endfunction

  function automatic m_t nxt_m(int R, int C, m_t m, bit s, int kl, bit st, bit ab);
    m_t n;
    int total;
    n = m;
    total = m.k + R + C - 2;
    if (!m.act) begin
      n.act = s;
      n.k = kl;
      n.p = 0;
    end else if (ab || m.k == 0 || m.p == total + 1) n.act = 0;
    else if (!(st && m.p >= 1 && m.p <= total)) n.p = m.p + 1;
    return n;
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) begin
      m1 <= '0;
      m2 <= '0;
    end else begin
      m1 <= nxt_m(4, 4, m1, start, int'(k_len), stall, abort);
      m2 <= nxt_m(2, 8, m2, start, int'(k_len), stall, abort);
    end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    rel = cyc - c0;
    e1 = model_out(4, 4, m1, stall, abort);
    e2 = model_out(2, 8, m2, stall, abort);
    g1 = {busy1, acc1, pe1, done1, 4'b0, a1, 4'b0, b1};
    g2 = {busy2, acc2, pe2, done2, 6'b0, a2, b2};
    chk("model_4x4", 64'(g1), 64'(e1));
    chk("model_2x8", 64'(g2), 64'(e2));
    if (rel == 0) begin
      {h_pe, h_a0, h_a3, h_b2, h_done, h_acc, h_busy} = '0;
      b7_first = -1;
      b7_last = -1;
      b7_cnt = 0;
      d2 = -1;
    end
    if (rel >= 0 && rel < 64) begin
      h_pe[rel] = pe1;
      h_a0[rel] = a1[0];
      h_a3[rel] = a1[3];
      h_b2[rel] = b1[2];
      h_done[rel] = done1;
      h_acc[rel] = acc1;
      h_busy[rel] = busy1;
    end
    if (b2[7]) begin
      if (b7_first < 0) b7_first = rel;
      b7_last = rel;
      b7_cnt++;
    end
    if (done2) d2 = rel;
  end

  task automatic go(input bit s, input int k, input bit st, input bit ab);
    @(negedge clk);
    start = s;
    k_len = 8'(k);
    stall = st;
    abort = ab;
  endtask

  task automatic begin_op(input int k);
    @(negedge clk);
    c0 = cyc;
    start = 1;
    k_len = 8'(k);
    stall = 0;
    abort = 0;
  endtask

  initial begin
    repeat (3) go(1, 4, 0, 0);
    #2;
    chk("reset_outputs", 64'({busy1, acc1, pe1, done1, a1, b1}), 64'(0));
    go(0, 0, 0, 0);
    rst = 1;
    go(0, 0, 0, 1);
    go(0, 0, 0, 1);
    go(0, 0, 0, 0);
    begin_op(4);
    for (int i = 1; i <= 15; i++) go(0, 0, 0, 0);
    #2;
    chk("t1_acc", h_acc, 64'h2);
    chk("t1_pe", h_pe, 64'hFFC);
    chk("t1_a0", h_a0, 64'h3C);
    chk("t1_a3", h_a3, 64'h1E0);
    chk("t1_b2", h_b2, 64'hF0);
    chk("t1_done", h_done, 64'h1000);
    chk("t1_busy", h_busy, 64'h1FFE);
    begin_op(4);
    for (int i = 1; i <= 17; i++) go(0, 0, i == 4 || i == 5, 0);
    #2;
    chk("t2_pe", h_pe, 64'h3FCC);
    chk("t2_a0", h_a0, 64'hCC);
    chk("t2_done", h_done, 64'h4000);
    begin_op(0);
    for (int i = 1; i <= 4; i++) go(0, 0, 0, 0);
    #2;
    chk("k0_done", h_done, 64'h2);
    chk("k0_busy", h_busy, 64'h2);
    chk("k0_acc", h_acc, 64'h0);
    chk("k0_pe", h_pe | h_a0 | h_a3 | h_b2, 64'h0);
    begin_op(4);
    for (int i = 1; i <= 24; i++) go(i == 8, 4, 0, i == 6);
    #2;
    chk("abort_acc", h_acc, 64'h202);
    chk("abort_done", h_done, 64'h100000);
    chk("abort_busy", h_busy, 64'h1FFE7E);
    begin_op(4);
    for (int i = 1; i <= 20; i++) begin
      go(0, 0, 0, 0);
      if (i == 5) rst = 0;
      if (i == 6) rst = 1;
    end
    #2;
    chk("rst_done", h_done, 64'h0);
    chk("rst_busy", h_busy, 64'h1E);
    begin_op(4);
    for (int i = 1; i <= 20; i++) go(i == 3 || i == 7 || i == 12, 9, 0, 0);
    #2;
    chk("ign_done", h_done, 64'h1000);
    chk("ign_busy", h_busy, 64'h1FFE);
    begin_op(1);
    for (int i = 1; i <= 10; i++) go(0, 0, 0, 0);
    #2;
    chk("k1_done", h_done, 64'h200);
    begin_op(1);
    for (int i = 1; i <= 10; i++) go(0, 0, 0, i == 9);
    #2;
    chk("abort_done_state", h_done, 64'h0);
    begin_op(255);
    for (int i = 1; i <= 270; i++) go(0, 0, 0, 0);
    #2;
    chk("big_done", 64'(d2), 64'd265);
    chk("big_b7_first", 64'(b7_first), 64'd9);
    chk("big_b7_last", 64'(b7_last), 64'd263);
    chk("big_b7_cnt", 64'(b7_cnt), 64'd255);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
